// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response handshake bundle between the MEM stage and the load/store controller
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store controller driving a synchronous data RAM port
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  mem_access_ctrl_if.slave    bus,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [3:0]          ram_sel,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [1:0]  lat_off;

  logic        misaligned;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  assign bus.req_ready = (state == IDLE) && !flush;

  always_comb begin
    misaligned = 1'b0;
    sel_nxt    = 4'hF;
    wdata_nxt  = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        sel_nxt   = 4'b0001 << bus.req_addr[1:0];
        wdata_nxt = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = bus.req_addr[0];
        sel_nxt    = 4'b0011 << bus.req_addr[1:0];
        wdata_nxt  = {2{bus.req_wdata[15:0]}};
      end
      2'd2: misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction uses the offset latched at accept; the RAM word arrives in DATA.
  always_comb begin
    byte_v    = ram_rdata[{lat_off, 3'b000} +: 8];
    half_v    = ram_rdata[{lat_off[1], 4'b0000} +: 16];
    load_data = ram_rdata;
    case (lat_size)
      2'd0:    load_data = {{24{~lat_uns & byte_v[7]}}, byte_v};
      2'd1:    load_data = {{16{~lat_uns & half_v[15]}}, half_v};
      default: load_data = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_we         <= 1'b0;
      lat_size       <= 2'd0;
      lat_uns        <= 1'b0;
      lat_off        <= 2'd0;
      ram_ce         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_sel        <= 4'h0;
      ram_wdata      <= 32'h0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && !flush) begin
            lat_we         <= bus.req_we;
            lat_size       <= bus.req_size;
            lat_uns        <= bus.req_unsigned;
            lat_off        <= bus.req_addr[1:0];
            bus.resp_rdata <= 32'h0;
            if (misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              ram_ce    <= 1'b1;
              ram_we    <= bus.req_we;
              ram_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              ram_sel   <= sel_nxt;
              ram_wdata <= wdata_nxt;
            end
          end
        end
        ACCESS: begin
          // The RAM cycle is already on the port, so a flush here still commits a store.
          ram_ce    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_sel   <= 4'h0;
          ram_wdata <= 32'h0;
          if (flush) begin
            state <= IDLE;
          end else if (lat_we) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_data;
          end
        end
        RESP: begin
          if (bus.resp_ready || flush) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural RAM and reference model
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          acc;
  } ram_op_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_sel;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_sel   (ram_sel),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          stall_cycles = 0;
  resp_t       resp_q[$];
  ram_op_t     ram_q[$];
  logic [31:0] ram_mem[0:63];
  logic [31:0] shadow[0:63];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural RAM: registered read, byte-lane writes.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        for (int i = 0; i < 4; i++)
          if (ram_sel[i]) ram_mem[ram_addr[7:2]][8*i +: 8] = ram_wdata[8*i +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr[7:2]];
      end
    end
  end

  function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit want_resp, input bit use_exp, input logic [31:0] exp_rdata);
    int      n;
    int      nbytes;
    resp_t   r;
    ram_op_t o;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    nbytes = 1 << size;
    r.acc  = cyc + 1;
    r.err  = model_mis(size, addr);
    r.lat  = r.err ? 1 : (we ? 2 : 3);
    r.rdata = 32'h0;
    if (!r.err && !we) r.rdata = use_exp ? exp_rdata : model_load(shadow[addr[7:2]], size, uns, addr);
    if (!r.err) begin
      o.we    = we;
      o.addr  = addr & ~32'd3;
      o.sel   = 4'(((1 << nbytes) - 1) << (addr % 4));
      o.wdata = (size == 2'd0) ? wd[7:0] * 32'h01010101 :
                (size == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
      o.acc   = r.acc;
      ram_q.push_back(o);
      if (we)
        for (int i = 0; i < nbytes; i++)
          shadow[addr[7:2]][8*((addr % 4) + i) +: 8] = wd[8*i +: 8];
    end
    if (want_resp) resp_q.push_back(r);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || ram_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queues", resp_q.size() + ram_q.size(), 32'd0);
  endtask

  // RAM-port monitor.
  initial begin
    ram_op_t o;
    forever begin
      @(negedge clk);
      if (rst_n && ram_ce) begin
        if (ram_q.size() == 0) begin
          chk("unexpected_ram_ce", 32'd1, 32'd0);
        end else begin
          o = ram_q.pop_front();
          chk("ram_we", ram_we, o.we);
          chk("ram_addr", ram_addr, o.addr);
          chk("ram_sel", ram_sel, o.sel);
          if (o.we) chk("ram_wdata", ram_wdata, o.wdata);
          chk("ram_ce_latency", cyc - o.acc + 1, 32'd1);
        end
      end
    end
  end

  // Response monitor; also owns resp_ready.
  initial begin
    resp_t       cur;
    bit          in_resp;
    bit          post_hs;
    int          hold;
    logic [31:0] held_rdata;
    logic        held_err;
    in_resp = 0;
    post_hs = 0;
    hold = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 0;
        post_hs = 0;
        hold = 0;
        bus.resp_ready = 1'b0;
      end else begin
        if (post_hs && !flush) chk("idle_after_handshake", bus.req_ready, 32'd1);
        post_hs = 0;
        if (bus.resp_valid && !in_resp) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            cur = resp_q.pop_front();
            chk("resp_latency", cyc - cur.acc + 1, cur.lat);
            chk("resp_rdata", bus.resp_rdata, cur.rdata);
            chk("resp_err", bus.resp_err, cur.err);
          end
          in_resp = 1;
          held_rdata = bus.resp_rdata;
          held_err = bus.resp_err;
          hold = stall_cycles;
          stall_cycles = 0;
        end else if (bus.resp_valid) begin
          chk("resp_rdata_stable", bus.resp_rdata, held_rdata);
          chk("resp_err_stable", bus.resp_err, held_err);
        end
        if (bus.resp_valid) begin
          if (hold > 0) begin
            bus.resp_ready = 1'b0;
            hold--;
            chk("req_ready_in_resp", bus.req_ready, 32'd0);
          end else begin
            bus.resp_ready = ($urandom % 3) != 0;
          end
          if (bus.resp_ready) begin
            in_resp = 0;
            post_hs = 1;
          end
        end else begin
          in_resp = 0;
          bus.resp_ready = 1'($urandom % 2);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    ram_rdata        = 32'h0;
    rst_n            = 1'b0;
    flush            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    #12;
    chk("rst_req_ready", bus.req_ready, 32'd1);
    chk("rst_resp_valid", bus.resp_valid, 32'd0);
    chk("rst_ram_ce", ram_ce, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte store with lane replication, then the word used for sign/zero extension loads.
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 1, 0, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 1, 0, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 1, 1, 32'hFFFFFFFF);
    issue(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 1, 1, 32'h000000FF);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1, 1, 32'hFFFF80FF);
    issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 1, 1, 32'h00007F01);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1, 1, 32'h80FF7F01);
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1, 1, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 1, 1, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, 1, 0, 32'h0);
    drain();

    // Back-pressure on a load response.
    stall_cycles = 5;
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1, 0, 32'h0);
    drain();

    // Flush during ACCESS of a store: write commits, no response.
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 0, 0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_access_req_ready", bus.req_ready, 32'd1);
    chk("flush_access_no_resp", bus.resp_valid, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1, 1, 32'hCAFEF00D);
    drain();

    // Flush during DATA of a load.
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_data_no_resp", bus.resp_valid, 32'd0);
    @(negedge clk);
    chk("flush_data_no_resp_late", bus.resp_valid, 32'd0);

    // Flush in IDLE blocks acceptance.
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h30;
    #1;
    chk("flush_idle_req_ready", bus.req_ready, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("flush_idle_no_resp", bus.resp_valid, 32'd0);
    bus.req_valid = 1'b0;
    flush = 1'b0;
    drain();

    // Asynchronous reset in the middle of an ACCESS cycle.
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ram_ce", ram_ce, 32'd0);
    chk("async_rst_resp_valid", bus.resp_valid, 32'd0);
    chk("async_rst_req_ready", bus.req_ready, 32'd1);
    if (resp_q.size() != 0) void'(resp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      a  = $urandom_range(0, 255);
      sz = 2'($urandom_range(0, 3));
      if ($urandom % 2) a = a & ~32'd3;
      issue(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, 1, 0, 32'h0);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
